// File: rtl/snes_pad_port.sv
// Controller-side responder for the console joypad ports: two standard pads,
// or a standard pad on port 1 plus a 4-pad multitap on port 2.
module snes_pad_port (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        MTAP_EN,
    input  logic        JOY_STRB,
    input  logic        JOY1_CLK,
    input  logic        JOY2_CLK,
    input  logic        JOY2_P6,
    input  logic [11:0] PAD1,
    input  logic [11:0] PAD2,
    input  logic [11:0] PAD3,
    input  logic [11:0] PAD4,
    input  logic [11:0] PAD5,
    output logic [1:0]  JOY1_DI,
    output logic [1:0]  JOY2_DI
);

    localparam int unsigned NPAD    = 5;
    localparam int unsigned BTN_W   = 12;
    localparam int unsigned SR_W    = 16;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned CNT_MAX = 16;

    logic [BTN_W-1:0] pad_in [NPAD];

    // Input sample stage
    logic             strb_q, clk1_q, clk2_q, p6_q, mtap_q;
    logic             clk1_prev_q, clk2_prev_q;
    logic [BTN_W-1:0] pad_q [NPAD];

    // Per-pad frame state, wire level: bit 0 is the bit currently on the line
    logic [SR_W-1:0]  sr_q  [NPAD];
    logic [SR_W-1:0]  sr_d  [NPAD];
    logic [CNT_W-1:0] cnt_q [NPAD];
    logic [CNT_W-1:0] cnt_d [NPAD];

    logic [1:0]       joy1_di_q, joy2_di_q;
    logic [1:0]       joy1_di_d, joy2_di_d;

    logic             edge1, edge2;
    logic [NPAD-1:0]  shift_en;
    logic [NPAD-1:0]  cur_bit;

    assign pad_in[0] = PAD1;
    assign pad_in[1] = PAD2;
    assign pad_in[2] = PAD3;
    assign pad_in[3] = PAD4;
    assign pad_in[4] = PAD5;

    assign JOY1_DI = joy1_di_q;
    assign JOY2_DI = joy2_di_q;

    // Next-state: latch/shift per pad and the output mux from the updated state
    always_comb begin
        edge1     = clk1_q & ~clk1_prev_q & ~strb_q;
        edge2     = clk2_q & ~clk2_prev_q & ~strb_q;
        shift_en  = '0;
        cur_bit   = '0;
        joy1_di_d = 2'b11;
        joy2_di_d = 2'b11;

        shift_en[0] = edge1;
        if (!mtap_q) begin
            shift_en[1] = edge2;
        end else if (p6_q) begin
            shift_en[1] = edge2;
            shift_en[2] = edge2;
        end else begin
            shift_en[3] = edge2;
            shift_en[4] = edge2;
        end

        for (int i = 0; i < NPAD; i++) begin
            sr_d[i]  = sr_q[i];
            cnt_d[i] = cnt_q[i];
            if (strb_q) begin
                sr_d[i]  = {4'hF, ~pad_q[i]};
                cnt_d[i] = '0;
            end else if (shift_en[i]) begin
                sr_d[i] = {1'b0, sr_q[i][SR_W-1:1]};
                if (cnt_q[i] != CNT_W'(CNT_MAX)) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            cur_bit[i] = (cnt_d[i] == CNT_W'(CNT_MAX)) ? 1'b0 : sr_d[i][0];
        end

        joy1_di_d = {1'b1, cur_bit[0]};
        if (!mtap_q) begin
            joy2_di_d = {1'b1, cur_bit[1]};
        end else if (p6_q) begin
            joy2_di_d = {cur_bit[2] & ~strb_q, cur_bit[1]};
        end else begin
            joy2_di_d = {cur_bit[4] & ~strb_q, cur_bit[3]};
        end
    end

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            strb_q      <= 1'b0;
            clk1_q      <= 1'b1;
            clk2_q      <= 1'b1;
            clk1_prev_q <= 1'b1;
            clk2_prev_q <= 1'b1;
            p6_q        <= 1'b1;
            mtap_q      <= 1'b0;
            for (int i = 0; i < NPAD; i++) begin
                pad_q[i] <= '0;
                sr_q[i]  <= '1;
                cnt_q[i] <= '0;
            end
            joy1_di_q   <= 2'b11;
            joy2_di_q   <= 2'b11;
        end else begin
            strb_q      <= JOY_STRB;
            clk1_q      <= JOY1_CLK;
            clk2_q      <= JOY2_CLK;
            clk1_prev_q <= clk1_q;
            clk2_prev_q <= clk2_q;
            p6_q        <= JOY2_P6;
            mtap_q      <= MTAP_EN;
            for (int i = 0; i < NPAD; i++) begin
                pad_q[i] <= pad_in[i];
                sr_q[i]  <= sr_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            joy1_di_q   <= joy1_di_d;
            joy2_di_q   <= joy2_di_d;
        end
    end

endmodule

// File: tb/tb_snes_pad_port.sv
// Self-checking bench for snes_pad_port: directed scenarios plus random
// traffic against a per-pad (buttons, bit position) reference model.
module tb_snes_pad_port;

    logic        MCLK;
    logic        RESET_N;
    logic        MTAP_EN;
    logic        JOY_STRB;
    logic        JOY1_CLK;
    logic        JOY2_CLK;
    logic        JOY2_P6;
    logic [11:0] pad [5];
    logic [1:0]  JOY1_DI;
    logic [1:0]  JOY2_DI;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buttons captured at the last latch and bits already shifted out
    logic [11:0] m_btn [5];
    int          m_pos [5];

    snes_pad_port dut (
        .MCLK     (MCLK),
        .RESET_N  (RESET_N),
        .MTAP_EN  (MTAP_EN),
        .JOY_STRB (JOY_STRB),
        .JOY1_CLK (JOY1_CLK),
        .JOY2_CLK (JOY2_CLK),
        .JOY2_P6  (JOY2_P6),
        .PAD1     (pad[0]),
        .PAD2     (pad[1]),
        .PAD3     (pad[2]),
        .PAD4     (pad[3]),
        .PAD5     (pad[4]),
        .JOY1_DI  (JOY1_DI),
        .JOY2_DI  (JOY2_DI)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    function automatic logic wire_bit(input logic [11:0] b, input int p);
        logic [11:0] t;
        t = b >> p;
        if (p < 12)      return ~t[0];
        else if (p < 16) return 1'b1;
        else             return 1'b0;
    endfunction

    function automatic logic [1:0] exp_j1();
        return {1'b1, wire_bit(m_btn[0], m_pos[0])};
    endfunction

    function automatic logic [1:0] exp_j2();
        if (!MTAP_EN)
            return {1'b1, wire_bit(m_btn[1], m_pos[1])};
        else if (JOY2_P6)
            return {(JOY_STRB ? 1'b0 : wire_bit(m_btn[2], m_pos[2])), wire_bit(m_btn[1], m_pos[1])};
        else
            return {(JOY_STRB ? 1'b0 : wire_bit(m_btn[4], m_pos[4])), wire_bit(m_btn[3], m_pos[3])};
    endfunction

    // After reset every line reads 1 until 16 shifts: same as a latch of no buttons
    task automatic m_reset();
        for (int i = 0; i < 5; i++) begin
            m_btn[i] = 12'h000;
            m_pos[i] = 0;
        end
    endtask

    task automatic m_latch();
        for (int i = 0; i < 5; i++) begin
            m_btn[i] = pad[i];
            m_pos[i] = 0;
        end
    endtask

    task automatic m_shift(input int i);
        if (m_pos[i] < 16) m_pos[i] = m_pos[i] + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic do_strobe(input int w);
        JOY_STRB = 1'b1;
        m_latch();
        tick(w);
        JOY_STRB = 1'b0;
        tick(2);
    endtask

    task automatic clk1_pulse(input int w);
        JOY1_CLK = 1'b0;
        tick(w);
        JOY1_CLK = 1'b1;
        tick(w);
        if (!JOY_STRB) m_shift(0);
    endtask

    task automatic clk2_pulse(input int w);
        JOY2_CLK = 1'b0;
        tick(w);
        JOY2_CLK = 1'b1;
        tick(w);
        if (!JOY_STRB) begin
            if (!MTAP_EN) m_shift(1);
            else if (JOY2_P6) begin m_shift(1); m_shift(2); end
            else begin m_shift(3); m_shift(4); end
        end
    endtask

    task automatic test_reset();
        RESET_N  = 1'b0;
        MTAP_EN  = 1'b0;
        JOY_STRB = 1'b0;
        JOY1_CLK = 1'b1;
        JOY2_CLK = 1'b1;
        JOY2_P6  = 1'b1;
        for (int i = 0; i < 5; i++) pad[i] = 12'h000;
        m_reset();
        tick(3);
        n_checks++;
        if (JOY1_DI !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_j1: got %b expected 11", JOY1_DI);
        end
        n_checks++;
        if (JOY2_DI !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_j2: got %b expected 11", JOY2_DI);
        end
        RESET_N = 1'b1;
        tick(2);
        n_checks++;
        if (JOY1_DI !== exp_j1() || JOY2_DI !== exp_j2()) begin
            n_fail++;
            $display("FAIL reset_release: got %b/%b expected %b/%b", JOY1_DI, JOY2_DI, exp_j1(), exp_j2());
        end
    endtask

    task automatic test_port1_seq();
        logic [16:0] seq;
        logic        e;
        seq = 17'h0FFF6;
        pad[0] = 12'h009;
        JOY_STRB = 1'b1;
        m_latch();
        tick(1);
        n_checks++;
        if (JOY1_DI !== 2'b11) begin
            n_fail++;
            $display("FAIL strobe_latency_early: got %b expected 11", JOY1_DI);
        end
        tick(1);
        n_checks++;
        if (JOY1_DI !== 2'b10) begin
            n_fail++;
            $display("FAIL strobe_latency: got %b expected 10", JOY1_DI);
        end
        tick(2);
        JOY_STRB = 1'b0;
        tick(2);
        for (int k = 0; k < 18; k++) begin
            e = (k < 17) ? seq[k] : 1'b0;
            n_checks++;
            if (JOY1_DI !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL p1_seq step %0d: got %b expected %b", k, JOY1_DI, {1'b1, e});
            end
            clk1_pulse(2);
            tick(2);
        end
    endtask

    task automatic test_reset_midframe();
        pad[0] = 12'h029;
        do_strobe(2);
        for (int k = 0; k < 5; k++) clk1_pulse(2);
        tick(2);
        n_checks++;
        if (JOY1_DI !== 2'b10) begin
            n_fail++;
            $display("FAIL midframe_down: got %b expected 10", JOY1_DI);
        end
        RESET_N = 1'b0;
        tick(1);
        RESET_N = 1'b1;
        m_reset();
        n_checks++;
        if (JOY1_DI !== 2'b11 || JOY2_DI !== 2'b11) begin
            n_fail++;
            $display("FAIL midframe_reset: got %b/%b expected 11/11", JOY1_DI, JOY2_DI);
        end
        pad[0] = 12'h000;
        do_strobe(2);
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (JOY1_DI !== {1'b1, (k < 16)}) begin
                n_fail++;
                $display("FAIL post_reset_frame step %0d: got %b expected %b", k, JOY1_DI, {1'b1, (k < 16)});
            end
            clk1_pulse(1);
            tick(2);
        end
    endtask

    task automatic test_mtap_pair_a();
        logic [1:0] e;
        MTAP_EN = 1'b1;
        JOY2_P6 = 1'b1;
        pad[1] = 12'h001;
        pad[2] = 12'h800;
        pad[3] = 12'($urandom);
        pad[4] = 12'($urandom);
        JOY_STRB = 1'b1;
        m_latch();
        tick(3);
        n_checks++;
        if (JOY2_DI !== 2'b00) begin
            n_fail++;
            $display("FAIL mtap_strobe_sig: got %b expected 00", JOY2_DI);
        end
        JOY_STRB = 1'b0;
        tick(2);
        for (int k = 0; k < 12; k++) begin
            e = {(k != 11), (k != 0)};
            n_checks++;
            if (JOY2_DI !== e) begin
                n_fail++;
                $display("FAIL mtap_pair_a step %0d: got %b expected %b", k, JOY2_DI, e);
            end
            clk2_pulse(1);
            tick(2);
        end
    endtask

    task automatic test_pair_switch();
        logic [11:0] pa, pb;
        MTAP_EN = 1'b1;
        JOY2_P6 = 1'b1;
        pa = 12'($urandom);
        pb = 12'($urandom);
        pad[1] = pa;
        pad[2] = pb;
        pad[3] = 12'h004;
        pad[4] = 12'($urandom);
        do_strobe(2);
        for (int k = 0; k < 3; k++) clk2_pulse(2);
        tick(2);
        n_checks++;
        if (JOY2_DI !== exp_j2()) begin
            n_fail++;
            $display("FAIL pair_a_3: got %b expected %b", JOY2_DI, exp_j2());
        end
        JOY2_P6 = 1'b0;
        tick(2);
        n_checks++;
        if (JOY2_DI[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pair_b_b: got %b expected 1", JOY2_DI[0]);
        end
        clk2_pulse(2);
        clk2_pulse(2);
        tick(2);
        n_checks++;
        if (JOY2_DI[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_b_select: got %b expected 0", JOY2_DI[0]);
        end
        JOY2_P6 = 1'b1;
        tick(2);
        n_checks++;
        if (JOY2_DI !== {~pb[3], ~pa[3]}) begin
            n_fail++;
            $display("FAIL pair_a_resume: got %b expected %b", JOY2_DI, {~pb[3], ~pa[3]});
        end
    endtask

    task automatic test_collision();
        MTAP_EN  = 1'b0;
        JOY1_CLK = 1'b0;
        tick(2);
        pad[0]   = 12'h002;
        JOY_STRB = 1'b1;
        JOY1_CLK = 1'b1;
        tick(2);
        pad[0]   = 12'h001;
        JOY1_CLK = 1'b0;
        tick(2);
        JOY1_CLK = 1'b1;
        tick(1);
        JOY_STRB = 1'b0;
        m_latch();
        tick(2);
        n_checks++;
        if (JOY1_DI !== 2'b10) begin
            n_fail++;
            $display("FAIL collision_b: got %b expected 10", JOY1_DI);
        end
        clk1_pulse(2);
        tick(2);
        n_checks++;
        if (JOY1_DI !== 2'b11) begin
            n_fail++;
            $display("FAIL collision_y: got %b expected 11", JOY1_DI);
        end
    endtask

    task automatic test_mtap_disabled();
        MTAP_EN = 1'b0;
        for (int i = 0; i < 5; i++) pad[i] = 12'($urandom);
        do_strobe(2);
        for (int k = 0; k < 18; k++) begin
            JOY2_P6 = ~JOY2_P6;
            clk2_pulse(1);
            tick(2);
            n_checks++;
            if (JOY2_DI !== {1'b1, wire_bit(m_btn[1], k + 1)}) begin
                n_fail++;
                $display("FAIL mtap_off step %0d: got %b expected %b", k, JOY2_DI, {1'b1, wire_bit(m_btn[1], k + 1)});
            end
        end
    endtask

    task automatic test_back_to_back();
        MTAP_EN = 1'b1;
        JOY2_P6 = 1'b0;
        for (int i = 0; i < 5; i++) pad[i] = 12'($urandom);
        do_strobe(1);
        for (int k = 0; k < 7; k++) begin
            clk1_pulse(1);
            clk2_pulse(1);
        end
        tick(2);
        n_checks++;
        if (JOY1_DI !== exp_j1() || JOY2_DI !== exp_j2()) begin
            n_fail++;
            $display("FAIL b2b_7: got %b/%b expected %b/%b", JOY1_DI, JOY2_DI, exp_j1(), exp_j2());
        end
        for (int k = 0; k < 12; k++) begin
            clk1_pulse(1);
            clk2_pulse(1);
        end
        tick(2);
        n_checks++;
        if (JOY1_DI !== 2'b10 || JOY2_DI !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_saturate: got %b/%b expected 10/00", JOY1_DI, JOY2_DI);
        end
    endtask

    task automatic test_random();
        int         op;
        logic [1:0] e1, e2;
        JOY_STRB = 1'b0;
        JOY1_CLK = 1'b1;
        JOY2_CLK = 1'b1;
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: begin
                    for (int i = 0; i < 5; i++) pad[i] = 12'($urandom);
                    do_strobe(int'($urandom_range(1, 3)));
                end
                1, 2: clk1_pulse(int'($urandom_range(1, 3)));
                3:    clk2_pulse(int'($urandom_range(1, 3)));
                4: begin
                    JOY2_P6 = ~JOY2_P6;
                    tick(1);
                end
                default: begin
                    MTAP_EN = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            endcase
            tick(2);
            e1 = exp_j1();
            e2 = exp_j2();
            n_checks++;
            if (JOY1_DI !== e1) begin
                n_fail++;
                $display("FAIL random_j1 it %0d: got %b expected %b", it, JOY1_DI, e1);
            end
            n_checks++;
            if (JOY2_DI !== e2) begin
                n_fail++;
                $display("FAIL random_j2 it %0d: got %b expected %b", it, JOY2_DI, e2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_port1_seq();
        test_reset_midframe();
        test_mtap_pair_a();
        test_pair_switch();
        test_collision();
        test_mtap_disabled();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
